// File: rtl/mem_burst_addr_gen_if.sv
// Request and memory-access signal bundle for the strided burst address generator.
interface mem_burst_addr_gen_if #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned LEN_WIDTH  = 5
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [ADDR_WIDTH-1:0] req_base;
   logic [ADDR_WIDTH-1:0] req_stride;
   logic [LEN_WIDTH-1:0]  req_len;
   logic                  mem_stall;
   logic                  read_enable;
   logic                  write_enable;
   logic [ADDR_WIDTH-1:0] mem_address;
   logic [LEN_WIDTH-1:0]  elem_index;
   logic                  busy;
   logic                  done;

   // Requester / memory side
   modport master (
      output req_valid, req_write, req_base, req_stride, req_len, mem_stall,
      input  req_ready, read_enable, write_enable, mem_address, elem_index, busy, done
   );

   // Address generator side
   modport slave (
      input  req_valid, req_write, req_base, req_stride, req_len, mem_stall,
      output req_ready, read_enable, write_enable, mem_address, elem_index, busy, done
   );
endinterface

// File: rtl/mem_burst_addr_gen.sv
// Strided burst address sequencer: accepts one burst request and emits one
// element address per cycle with read or write enable, honouring mem_stall.
module mem_burst_addr_gen #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned MAX_LEN    = 16,
   parameter int unsigned LEN_WIDTH  = 5
) (
   input logic                 clk,
   input logic                 rst,
   mem_burst_addr_gen_if.slave bus
);

   localparam logic [LEN_WIDTH-1:0] MAX_LEN_L = LEN_WIDTH'(MAX_LEN);
   localparam logic [LEN_WIDTH-1:0] ONE_L     = LEN_WIDTH'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] stride_q, stride_d;
   logic                  write_q, write_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LEN_WIDTH-1:0]  idx_q, idx_d;
   logic                  ren_q, ren_d;
   logic                  wen_q, wen_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic [LEN_WIDTH-1:0]  len_clamp;

   // Oversized requests are clamped to the maximum burst length
   assign len_clamp = (bus.req_len > MAX_LEN_L) ? MAX_LEN_L : bus.req_len;

   // Next-state and next-output decode
   always_comb begin
      state_d  = state_q;
      stride_d = stride_q;
      write_d  = write_q;
      len_d    = len_q;
      addr_d   = addr_q;
      idx_d    = idx_q;
      ren_d    = ren_q;
      wen_d    = wen_q;
      busy_d   = busy_q;
      done_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               stride_d = bus.req_stride;
               write_d  = bus.req_write;
               len_d    = len_clamp;
               busy_d   = 1'b1;
               if (len_clamp == '0) begin
                  // Empty burst: straight to completion, no access issued
                  state_d = DONE;
                  done_d  = 1'b1;
                  ren_d   = 1'b0;
                  wen_d   = 1'b0;
               end else begin
                  state_d = ISSUE;
                  addr_d  = bus.req_base;
                  idx_d   = '0;
                  ren_d   = ~bus.req_write;
                  wen_d   = bus.req_write;
               end
            end
         end

         ISSUE: begin
            if (!bus.mem_stall) begin
               if (idx_q == (len_q - ONE_L)) begin
                  state_d = DONE;
                  ren_d   = 1'b0;
                  wen_d   = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  // Address wraps silently modulo 2^ADDR_WIDTH
                  addr_d = addr_q + stride_q;
                  idx_d  = idx_q + ONE_L;
               end
            end
         end

         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end

         default: begin
            state_d = IDLE;
            ren_d   = 1'b0;
            wen_d   = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         stride_q <= '0;
         write_q  <= 1'b0;
         len_q    <= '0;
         addr_q   <= '0;
         idx_q    <= '0;
         ren_q    <= 1'b0;
         wen_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         stride_q <= stride_d;
         write_q  <= write_d;
         len_q    <= len_d;
         addr_q   <= addr_d;
         idx_q    <= idx_d;
         ren_q    <= ren_d;
         wen_q    <= wen_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   // The latched direction is only needed to keep the request record complete
   logic unused_write;
   assign unused_write = write_q;

   assign bus.req_ready    = (state_q == IDLE);
   assign bus.read_enable  = ren_q;
   assign bus.write_enable = wen_q;
   assign bus.mem_address  = addr_q;
   assign bus.elem_index   = idx_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;

endmodule

// File: tb/tb_mem_burst_addr_gen.sv
// Self-checking bench for mem_burst_addr_gen: directed scenarios plus random
// bursts compared against an arithmetic address model (base + k*stride).
module tb_mem_burst_addr_gen;

   localparam int unsigned AW   = 16;
   localparam int unsigned LW   = 5;
   localparam int unsigned MAXL = 16;

   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;

   mem_burst_addr_gen_if #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

   mem_burst_addr_gen #(.ADDR_WIDTH(AW), .MAX_LEN(MAXL), .LEN_WIDTH(LW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "/ren"},   32'(bus.read_enable),  32'd0);
      check({tag, "/wen"},   32'(bus.write_enable), 32'd0);
      check({tag, "/addr"},  32'(bus.mem_address),  32'd0);
      check({tag, "/idx"},   32'(bus.elem_index),   32'd0);
      check({tag, "/busy"},  32'(bus.busy),         32'd0);
      check({tag, "/done"},  32'(bus.done),         32'd0);
      check({tag, "/ready"}, 32'(bus.req_ready),    32'd1);
   endtask

   // Drive one burst and check every cycle against the arithmetic model.
   task automatic run_burst(input string tag, input logic [15:0] base, input logic [15:0] stride,
                            input logic [4:0] len, input logic wr, input logic [63:0] stall_mask,
                            input bit rand_stall, input bit inject);
      int          elen;
      int          k;
      int          cyc;
      logic        stall;
      logic [15:0] last_addr;
      elen = (int'(len) > int'(MAXL)) ? int'(MAXL) : int'(len);
      last_addr = 16'(32'(base) + 32'(elen - 1) * 32'(stride));
      check({tag, "/pre_ready"}, 32'(bus.req_ready), 32'd1);
      bus.req_valid  = 1'b1;
      bus.req_write  = wr;
      bus.req_base   = base;
      bus.req_stride = stride;
      bus.req_len    = len;
      bus.mem_stall  = 1'b0;
      step();
      bus.req_valid = inject;
      if (inject) begin
         bus.req_base  = 16'h0500;
         bus.req_write = ~wr;
         bus.req_len   = 5'd3;
      end
      if (elen == 0) begin
         check({tag, "/len0_done"},  32'(bus.done),         32'd1);
         check({tag, "/len0_busy"},  32'(bus.busy),         32'd1);
         check({tag, "/len0_ren"},   32'(bus.read_enable),  32'd0);
         check({tag, "/len0_wen"},   32'(bus.write_enable), 32'd0);
         check({tag, "/len0_ready"}, 32'(bus.req_ready),    32'd0);
         bus.mem_stall = 1'($urandom_range(0, 1));
         step();
      end else begin
         k   = 0;
         cyc = 0;
         while (k < elen && cyc < 200) begin
            check({tag, "/ren"},   32'(bus.read_enable),  32'(!wr));
            check({tag, "/wen"},   32'(bus.write_enable), 32'(wr));
            check({tag, "/addr"},  32'(bus.mem_address),  32'(16'(32'(base) + 32'(k) * 32'(stride))));
            check({tag, "/idx"},   32'(bus.elem_index),   32'(k));
            check({tag, "/busy"},  32'(bus.busy),         32'd1);
            check({tag, "/done"},  32'(bus.done),         32'd0);
            check({tag, "/ready"}, 32'(bus.req_ready),    32'd0);
            if (rand_stall) stall = ($urandom_range(0, 3) == 0);
            else            stall = (cyc < 64) ? stall_mask[cyc] : 1'b0;
            bus.mem_stall = stall;
            step();
            if (!stall) k++;
            cyc++;
         end
         if (k < elen) check({tag, "/issue_timeout"}, 32'(k), 32'(elen));
         check({tag, "/end_done"},  32'(bus.done),         32'd1);
         check({tag, "/end_busy"},  32'(bus.busy),         32'd1);
         check({tag, "/end_ren"},   32'(bus.read_enable),  32'd0);
         check({tag, "/end_wen"},   32'(bus.write_enable), 32'd0);
         check({tag, "/end_ready"}, 32'(bus.req_ready),    32'd0);
         check({tag, "/end_addr"},  32'(bus.mem_address),  32'(last_addr));
         check({tag, "/end_idx"},   32'(bus.elem_index),   32'(elen - 1));
         bus.mem_stall = 1'($urandom_range(0, 1));
         step();
      end
      bus.req_valid = 1'b0;
      bus.mem_stall = 1'b0;
      check({tag, "/post_done"},  32'(bus.done),         32'd0);
      check({tag, "/post_busy"},  32'(bus.busy),         32'd0);
      check({tag, "/post_ready"}, 32'(bus.req_ready),    32'd1);
      check({tag, "/post_ren"},   32'(bus.read_enable),  32'd0);
      check({tag, "/post_wen"},   32'(bus.write_enable), 32'd0);
      if (elen > 0) begin
         check({tag, "/post_addr"}, 32'(bus.mem_address), 32'(last_addr));
         check({tag, "/post_idx"},  32'(bus.elem_index),  32'(elen - 1));
      end
   endtask

   initial begin
      rst            = 1'b1;
      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_base   = '0;
      bus.req_stride = '0;
      bus.req_len    = '0;
      bus.mem_stall  = 1'b0;
      step();
      step();
      check_reset_vals("reset");
      rst = 1'b0;
      step();

      // Directed scenarios
      run_burst("read4",  16'h0100, 16'd4, 5'd4,  1'b0, 64'd0,      1'b0, 1'b0);
      run_burst("wstall", 16'h2000, 16'd2, 5'd3,  1'b1, 64'b110,    1'b0, 1'b0);
      run_burst("wrap",   16'hFFFC, 16'd4, 5'd3,  1'b0, 64'd0,      1'b0, 1'b0);
      run_burst("len0",   16'h1234, 16'd8, 5'd0,  1'b1, 64'd0,      1'b0, 1'b0);
      run_burst("len20",  16'h0040, 16'd1, 5'd20, 1'b1, 64'd0,      1'b0, 1'b0);
      run_burst("len16",  16'h0080, 16'd3, 5'd16, 1'b0, 64'd0,      1'b0, 1'b0);
      run_burst("busy",   16'h0100, 16'd4, 5'd4,  1'b0, 64'd0,      1'b0, 1'b1);
      run_burst("str0",   16'h0777, 16'd0, 5'd5,  1'b1, 64'b1010,   1'b0, 1'b0);

      // Reset while elem_index = 2
      bus.req_valid  = 1'b1;
      bus.req_write  = 1'b0;
      bus.req_base   = 16'h0100;
      bus.req_stride = 16'd4;
      bus.req_len    = 5'd8;
      step();
      bus.req_valid = 1'b0;
      step();
      step();
      check("midrst/idx",  32'(bus.elem_index),  32'd2);
      check("midrst/addr", 32'(bus.mem_address), 32'h0108);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_reset_vals("midrst");

      // Reset and request at the same edge: request dropped
      rst           = 1'b1;
      bus.req_valid = 1'b1;
      bus.req_len   = 5'd4;
      step();
      rst           = 1'b0;
      bus.req_valid = 1'b0;
      check_reset_vals("rstreq");
      step();
      check("rstreq/still_idle", 32'(bus.busy), 32'd0);

      run_burst("after_rst", 16'h0300, 16'd16, 5'd4, 1'b1, 64'd0, 1'b0, 1'b0);

      // Random bursts
      for (int i = 0; i < 40; i++) begin
         logic [15:0] b;
         logic [15:0] s;
         b = 16'($urandom);
         s = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom);
         run_burst("rand", b, s, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                   64'd0, 1'b1, 1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_burst_addr_gen.md
Name: mem_burst_addr_gen

Overview:
- Upstream address sequencer for mem_addr_mananger.
- Accepts one strided burst request from the vector load/store unit.
- Emits one element address per cycle with read_enable or write_enable asserted, and these drive mem_addr_mananger input_address, read_enable and write_enable directly.
- Supports memory back-pressure through a stall input and pulses done when the burst completes.

Parameters:
ADDR_WIDTH, 16, width of base, stride and output address.
MAX_LEN, 16, maximum elements per burst; larger requests are clamped.
LEN_WIDTH, 5, width of req_len; must satisfy 2^LEN_WIDTH > MAX_LEN.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  reset, synchronous, active-high.
req_valid  input  1  burst request present.
req_ready  output  1  block can accept a request this cycle.
req_write  input  1  1 = store burst (write_enable), 0 = load burst (read_enable).
req_base  input  ADDR_WIDTH  address of element 0.
req_stride  input  ADDR_WIDTH  unsigned address increment per element.
req_len  input  LEN_WIDTH  element count.
mem_stall  input  1  memory not ready; hold the current access.
read_enable  output  1  load access valid this cycle.
write_enable  output  1  store access valid this cycle.
mem_address  output  ADDR_WIDTH  current element address.
elem_index  output  LEN_WIDTH  index of current element, 0-based.
busy  output  1  burst in progress (ISSUE or DONE).
done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (rst=1 at an edge, including mid-burst): state=IDLE and all latched request fields cleared. Outputs next cycle: read_enable=0, write_enable=0, mem_address=0, elem_index=0, busy=0, done=0, req_ready=1.
- All outputs are registered except req_ready, which is decoded from state (1 only in IDLE).
- Three states: IDLE, ISSUE and DONE.
- IDLE:
  - Handshake occurs when req_valid=1 at an edge; there is no wait on anything else.
  - On handshake, latch base, stride and write. Latch len as min(req_len, MAX_LEN).
  - If the latched len is 0, go to DONE with no enables asserted.
  - Otherwise go to ISSUE. In the same edge, load mem_address=req_base and elem_index=0, and assert the enable selected by req_write. The other enable stays 0.
  - Latency: the first access is visible in the cycle after the accepting edge.
- ISSUE:
  - An access completes at an edge where mem_stall=0.
  - On a completed access that is not the last element: mem_address += stride, modulo 2^ADDR_WIDTH (silent wrap, no flag); elem_index += 1; the enable stays asserted.
  - On completion of element len-1: deassert both enables, set done=1, go to DONE.
  - While mem_stall=1, mem_address, elem_index and the enables hold their values.
  - A burst of N elements with no stalls occupies exactly N consecutive cycles with an enable high.
- DONE:
  - Lasts one cycle: done=1, busy=1, enables=0.
  - Next edge: done=0, busy=0, return to IDLE.
  - mem_stall is ignored in DONE.
- Requests are ignored while not in IDLE. req_valid is not latched and has no effect on state.
- read_enable and write_enable are never both 1.
- mem_address and elem_index keep their last values after the burst; downstream must qualify them with the enables.
- If rst and req_valid are both high at the same edge, reset wins and the request is dropped.
- Stride 0 is legal: the same address repeats len times.

Test Plan:
1. Read burst: base=0x0100, stride=4, len=4, write=0, no stall.
   - mem_address must be 0x0100, 0x0104, 0x0108, 0x010C on 4 consecutive cycles with read_enable=1 and elem_index 0..3.
   - done=1 in the 5th cycle; req_ready=1 in the 6th.
2. Write burst with stall: base=0x2000, stride=2, len=3, write=1; mem_stall=1 during element 1 for 2 cycles.
   - Required: write_enable held, 0x2002 held for 3 cycles, then 0x2004.
   - 5 enable cycles total, then done; read_enable stays 0 throughout.
3. Wrap-around: base=0xFFFC, stride=4, len=3.
   - Required addresses: 0xFFFC, 0x0000, 0x0004; no error and no extra cycles.
4. Length edge cases:
   - len=0: no enable asserted, done in the cycle after accept.
   - len=20: clamped to 16, so exactly 16 accesses with elem_index ending at 15.
5. Busy rejection: assert a second req_valid (base=0x0500) during the scenario-1 burst.
   - Required: ignored, req_ready=0 throughout ISSUE and DONE, and the 0x01xx addresses are unaffected.
6. Reset mid-burst: rst=1 for 1 cycle while elem_index=2.
   - Next cycle all outputs at reset values and req_ready=1; a new request is accepted normally afterwards.
